// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-ported memory between a video refresh reader and a host
// CPU port. Each granted access takes three cycles: ISSUE (chip select),
// WAIT (memory acknowledges) and IDLE (arbitration). Video normally wins.
// The host wins once it has watched STARVE_MAX video grants go by in a row.
//
// Ports
//   i_clk, i_reset        system clock, synchronous active-high reset
//   i_vid_req/i_vid_addr  video read request (held until o_vid_ack)
//   o_vid_dat/o_vid_ack   video read data, qualified by one-cycle ack
//   i_host_req/i_host_we  host request and write enable (held until o_host_ack)
//   i_host_addr/i_host_dat host address and write data
//   o_host_dat/o_host_ack host read data, qualified by one-cycle ack
//   o_mem_cs/o_mem_we     memory strobe and write enable (registered)
//   o_mem_addr/o_mem_dat  memory address and write data (registered)
//   i_mem_dat/i_mem_ack   memory read data and ack, one cycle after o_mem_cs

module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_vid_req,
  input  logic [12:0] i_vid_addr,
  output logic [15:0] o_vid_dat,
  output logic        o_vid_ack,
  input  logic        i_host_req,
  input  logic        i_host_we,
  input  logic [12:0] i_host_addr,
  input  logic [15:0] i_host_dat,
  output logic [15:0] o_host_dat,
  output logic        o_host_ack,
  output logic        o_mem_cs,
  output logic        o_mem_we,
  output logic [12:0] o_mem_addr,
  output logic [15:0] o_mem_dat,
  input  logic [15:0] i_mem_dat,
  input  logic        i_mem_ack
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_HOST = 2'd2
  } owner_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      state, state_n;
  owner_t      owner, owner_n;
  logic [3:0]  starve_cnt, starve_cnt_n;
  logic        mem_cs_n;
  logic        mem_we_n;
  logic [12:0] mem_addr_n;
  logic [15:0] mem_dat_n;

  logic host_win;
  logic vid_win;

  // The host only beats a pending video request once the starve counter has
  // reached its limit; otherwise it wins only when video is not asking.
  assign host_win = i_host_req && (!i_vid_req || (starve_cnt == STARVE_LIM));
  assign vid_win  = i_vid_req && !host_win;

  // Next-state, owner, starve counter and memory-side outputs. The memory
  // pins are computed here and registered, so they are glitch-free and
  // appear in the cycle after the request is sampled.
  always_comb begin
    state_n      = state;
    owner_n      = owner;
    starve_cnt_n = starve_cnt;
    mem_cs_n     = 1'b0;
    mem_we_n     = 1'b0;
    mem_addr_n   = o_mem_addr;
    mem_dat_n    = o_mem_dat;

    case (state)
      ST_IDLE: begin
        owner_n = OWN_NONE;
        // Any pass through IDLE without a waiting host means nobody is
        // being starved, so the count restarts.
        if (!i_host_req) begin
          starve_cnt_n = 4'd0;
        end
        if (host_win) begin
          state_n      = ST_ISSUE;
          owner_n      = OWN_HOST;
          starve_cnt_n = 4'd0;
          mem_cs_n     = 1'b1;
          mem_we_n     = i_host_we;
          mem_addr_n   = i_host_addr;
          mem_dat_n    = i_host_dat;
        end else if (vid_win) begin
          state_n    = ST_ISSUE;
          owner_n    = OWN_VID;
          mem_cs_n   = 1'b1;
          mem_we_n   = 1'b0;
          mem_addr_n = i_vid_addr;
          mem_dat_n  = 16'h0000;
          if (i_host_req && (starve_cnt != STARVE_LIM)) begin
            starve_cnt_n = starve_cnt + 4'd1;
          end
        end
      end

      ST_ISSUE: begin
        state_n = ST_WAIT;
      end

      ST_WAIT: begin
        if (i_mem_ack) begin
          state_n = ST_IDLE;
          owner_n = OWN_NONE;
        end
      end

      default: begin
        state_n = ST_IDLE;
        owner_n = OWN_NONE;
      end
    endcase
  end

  // State and memory-side registers. Reset drops any in-flight access, so a
  // late memory ack lands in IDLE and is ignored.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      owner      <= OWN_NONE;
      starve_cnt <= 4'd0;
      o_mem_cs   <= 1'b0;
      o_mem_we   <= 1'b0;
      o_mem_addr <= 13'h0000;
      o_mem_dat  <= 16'h0000;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      starve_cnt <= starve_cnt_n;
      o_mem_cs   <= mem_cs_n;
      o_mem_we   <= mem_we_n;
      o_mem_addr <= mem_addr_n;
      o_mem_dat  <= mem_dat_n;
    end
  end

  // Acks are combinational from the memory ack so each requester sees its
  // data in the same cycle the memory returns it.
  assign o_vid_ack  = i_mem_ack && (state == ST_WAIT) && (owner == OWN_VID);
  assign o_host_ack = i_mem_ack && (state == ST_WAIT) && (owner == OWN_HOST);
  assign o_vid_dat  = o_vid_ack  ? i_mem_dat : 16'h0000;
  assign o_host_dat = o_host_ack ? i_mem_dat : 16'h0000;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, sets the maximum consecutive video grants while a host request waits; legal range 1..15.
REQ-002 i_clk  input  1  single system clock; all state changes on rising edge.
REQ-003 i_reset  input  1  synchronous, active-high reset.
REQ-004 i_vid_req  input  1  video read request; held until o_vid_ack.
REQ-005 i_vid_addr  input  13  video word address (font 0x0000-0x0FFF, screen 0x1000-0x1FFF).
REQ-006 o_vid_dat  output  16  video read data, valid while o_vid_ack=1.
REQ-007 o_vid_ack  output  1  video access complete, one-cycle pulse.
REQ-008 i_host_req  input  1  host request; held until o_host_ack.
REQ-009 i_host_we  input  1  host write enable (1=write, 0=read).
REQ-010 i_host_addr  input  13  host word address.
REQ-011 i_host_dat  input  16  host write data.
REQ-012 o_host_dat  output  16  host read data, valid while o_host_ack=1.
REQ-013 o_host_ack  output  1  host access complete, one-cycle pulse.
REQ-014 o_mem_cs  output  1  memory chip select.
REQ-015 o_mem_we  output  1  memory write enable.
REQ-016 o_mem_addr  output  13  memory address.
REQ-017 o_mem_dat  output  16  memory write data.
REQ-018 i_mem_dat  input  16  memory read data.
REQ-019 i_mem_ack  input  1  memory ack; arrives exactly one cycle after o_mem_cs.

Function
REQ-020 States: IDLE, ISSUE, WAIT; plus owner register {NONE, VID, HOST}.
REQ-021 IDLE: no request -> stay IDLE, owner NONE; any request -> ISSUE with winner registered as owner.
REQ-022 Priority: video wins when both requests pending, unless starve counter == STARVE_MAX, then host wins.
REQ-023 Starve counter (4 bits): increments on a video grant while i_host_req=1; clears on host grant or on any arbitration with i_host_req=0; saturates at STARVE_MAX.
REQ-024 On entry to ISSUE, o_mem_cs=1, o_mem_addr/o_mem_we/o_mem_dat are registered from the winner; o_mem_we=i_host_we for host, 0 for video; o_mem_dat=i_host_dat for host, 0 for video.
REQ-025 ISSUE lasts exactly one cycle, then -> WAIT with o_mem_cs=0, o_mem_we=0; address/data hold their values.
REQ-026 WAIT: while i_mem_ack=0, stay WAIT; o_mem_cs never reasserts.
REQ-027 o_vid_ack = i_mem_ack AND state==WAIT AND owner==VID; o_host_ack likewise for HOST; combinational.
REQ-028 o_vid_dat and o_host_dat = i_mem_dat when their ack is high, else 0.
REQ-029 WAIT with i_mem_ack=1 -> IDLE, owner NONE.
REQ-030 Access timing: request sampled at edge E0, cs high in cycle E0-E1, ack high in cycle E1-E2, IDLE in cycle E2-E3; next grant at E3 (3 cycles/access).
REQ-031 Requesters drop or replace request at the edge ending the ack cycle; a request still high in IDLE is a new access.
REQ-032 Request changes during ISSUE/WAIT have no effect on the in-flight access.
REQ-033 i_mem_ack while owner==NONE or state!=WAIT is ignored; no ack output.
REQ-034 Memory sees at most one cs cycle per granted access; never a write for a video access.

Reset
REQ-035 Reset: state IDLE, owner NONE, starve counter 0, o_mem_cs=0, o_mem_we=0, o_mem_addr=0, o_mem_dat=0; o_vid_ack=o_host_ack=0; o_vid_dat=o_host_dat=0.
REQ-036 Reset mid-access abandons it; no ack issued for it, late i_mem_ack ignored; arbitration resumes from IDLE the cycle after reset deasserts.

Verification
REQ-037 Host write 0x1005<=0xABCD alone -> cs=1 one cycle with we=1, addr 0x1005; o_host_ack two cycles after request; host read 0x1005 returns 0xABCD.
REQ-038 Video read 0x0010 and host read 0x1000 asserted same cycle -> video acked first (font word), host granted at next IDLE, acked 3 cycles later.
REQ-039 Video request held continuously, host pending, STARVE_MAX=4 -> exactly 4 video grants, then 1 host grant, counter back to 0.
REQ-040 Reset asserted during WAIT of host write -> no o_host_ack, cs stays 0, next access after reset completes normally.
REQ-041 Requester holds i_vid_req one cycle past ack -> second video access issued, proving REQ-031; video access never drives o_mem_we=1.
REQ-042 Spurious i_mem_ack injected in IDLE -> no ack output, state unchanged.
